// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use hazard unit
//
// Purpose:
//   Registers decoded ID fields into the EX slot and drives the ALU inputs.
//   ALU operands are forwarded from the EX/MEM and MEM/WB stages.
//   A load-use hazard inserts a bubble; a taken branch/jump squashes the slot.
//   stall_cnt is a saturating count of load-use stall cycles.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   id_*                          decoded instruction fields from ID
//   mem_stall                     freeze: hold all EX state
//   branch_taken                  taken branch/jump resolved in EX this cycle
//   exm_rd/_reg_write/_result     EX/MEM forwarding source
//   wb_rd/_reg_write/_result      MEM/WB forwarding source
//   ex_valid, ex_pc, ex_in1, ex_in2, ex_alu_ctrl, ex_store_data, ex_rd,
//   ex_reg_write, ex_mem_read, ex_mem_write   EX slot outputs
//   stall_id                      hold PC and IF/ID this cycle (combinational)
//   stall_cnt                     saturating load-use stall counter
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [3:0]        id_alu_ctrl,
  input  logic              id_use_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              mem_stall,
  input  logic              branch_taken,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic [XLEN-1:0]   exm_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_result,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_in1,
  output logic [XLEN-1:0]   ex_in2,
  output logic [3:0]        ex_alu_ctrl,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              stall_id,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [3:0] CTRL_NOP = 4'hF;

  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   rs2_data_q;
  logic [XLEN-1:0]   imm_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic              use_imm_q;
  logic [XLEN-1:0]   fwd1;
  logic [XLEN-1:0]   fwd2;
  logic              flush;
  logic              load_use;

  // Load in EX whose rd is read by the instruction in ID. A taken branch
  // kills the ID instruction anyway, and a freeze holds everything, so
  // neither should report a stall.
  assign load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                    ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));
  assign stall_id = load_use && !branch_taken && !mem_stall;
  assign flush    = branch_taken && ex_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      ex_rd        <= '0;
      use_imm_q    <= 1'b0;
      ex_alu_ctrl  <= CTRL_NOP;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      stall_cnt    <= '0;
    end else if (mem_stall) begin
      // hold all EX state
    end else if (flush || stall_id) begin
      // Bubble; payload is zeroed so the slot content is deterministic.
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      ex_rd        <= '0;
      use_imm_q    <= 1'b0;
      ex_alu_ctrl  <= CTRL_NOP;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      if (!flush && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      rs1_data_q   <= id_rs1_data;
      rs2_data_q   <= id_rs2_data;
      imm_q        <= id_imm;
      rs1_q        <= id_rs1;
      rs2_q        <= id_rs2;
      ex_rd        <= id_rd;
      use_imm_q    <= id_use_imm;
      ex_alu_ctrl  <= id_valid ? id_alu_ctrl : CTRL_NOP;
      ex_reg_write <= id_reg_write & id_valid;
      ex_mem_read  <= id_mem_read  & id_valid;
      ex_mem_write <= id_mem_write & id_valid;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB. x0 never forwards.
  always_comb begin
    fwd1 = rs1_data_q;
    if (exm_reg_write && exm_rd != '0 && exm_rd == rs1_q) begin
      fwd1 = exm_result;
    end else if (wb_reg_write && wb_rd != '0 && wb_rd == rs1_q) begin
      fwd1 = wb_result;
    end
  end

  always_comb begin
    fwd2 = rs2_data_q;
    if (exm_reg_write && exm_rd != '0 && exm_rd == rs2_q) begin
      fwd2 = exm_result;
    end else if (wb_reg_write && wb_rd != '0 && wb_rd == rs2_q) begin
      fwd2 = wb_result;
    end
  end

  assign ex_in1        = fwd1;
  assign ex_in2        = use_imm_q ? imm_q : fwd2;
  assign ex_store_data = fwd2;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        id_use_imm, id_reg_write, id_mem_read, id_mem_write;
  logic        mem_stall, branch_taken;
  logic [4:0]  exm_rd, wb_rd;
  logic        exm_reg_write, wb_reg_write;
  logic [31:0] exm_result, wb_result;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_in1, ex_in2, ex_store_data;
  logic [3:0]  ex_alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        stall_id;
  logic [3:0]  stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
    .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_stall(mem_stall), .branch_taken(branch_taken),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_in1(ex_in1), .ex_in2(ex_in2),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .stall_id(stall_id), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] r1d,
                        input logic [31:0] r2d, input logic [31:0] imm,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic [3:0] ctrl, input logic ui, input logic rw,
                        input logic mr, input logic mw);
    id_valid = v; id_pc = pc; id_rs1_data = r1d; id_rs2_data = r2d; id_imm = imm;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_alu_ctrl = ctrl;
    id_use_imm = ui; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic clr_fwd();
    exm_rd = '0; exm_reg_write = 1'b0; exm_result = '0;
    wb_rd = '0; wb_reg_write = 1'b0; wb_result = '0;
  endtask

  initial begin
    rst = 1'b1; mem_stall = 1'b0; branch_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clr_fwd();
    step(); step();
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ctrl", {28'd0, ex_alu_ctrl}, 32'hF);
    check("rst_cnt", {28'd0, stall_cnt}, 32'd0);
    check("rst_in1", ex_in1, 32'd0);
    rst = 1'b0;

    // invalid ID slot: control gated, ctrl F
    set_id(0, 32'h50, 1, 2, 0, 1, 2, 7, 4'h2, 0, 1, 1, 1);
    step();
    check("inv_valid", {31'd0, ex_valid}, 32'd0);
    check("inv_ctrl", {28'd0, ex_alu_ctrl}, 32'hF);
    check("inv_rw", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);

    // ADD x3,x1,x2
    set_id(1, 32'h100, 32'h5, 32'hB, 0, 1, 2, 3, 4'h0, 0, 1, 0, 0);
    step();
    check("add_valid", {31'd0, ex_valid}, 32'd1);
    check("add_pc", ex_pc, 32'h100);
    check("add_in1", ex_in1, 32'h5);
    check("add_in2", ex_in2, 32'hB);
    check("add_rd", {27'd0, ex_rd}, 32'd3);
    check("add_ctrl", {28'd0, ex_alu_ctrl}, 32'h0);
    // SUB x4,x3,x1; ADD result now in EX/MEM
    set_id(1, 32'h104, 32'hDEAD, 32'h5, 0, 3, 1, 4, 4'h1, 0, 1, 0, 0);
    step();
    exm_rd = 5'd3; exm_reg_write = 1'b1; exm_result = 32'h10;
    wb_rd = 5'd3; wb_reg_write = 1'b1; wb_result = 32'h99;
    #1;
    check("sub_in1_fwd", ex_in1, 32'h10);
    check("sub_in2", ex_in2, 32'h5);
    check("sub_store", ex_store_data, 32'h5);
    clr_fwd();

    // priority EX/MEM over MEM/WB, immediate operand
    set_id(1, 32'h108, 32'h1, 32'h22, 32'h44, 5, 0, 8, 4'h0, 1, 1, 0, 0);
    step();
    exm_rd = 5'd5; exm_reg_write = 1'b1; exm_result = 32'h7;
    wb_rd = 5'd5; wb_reg_write = 1'b1; wb_result = 32'h9;
    #1;
    check("prio_in1", ex_in1, 32'h7);
    check("imm_in2", ex_in2, 32'h44);
    check("imm_store", ex_store_data, 32'h22);
    exm_reg_write = 1'b0; #1;
    check("wb_in1", ex_in1, 32'h9);
    wb_reg_write = 1'b0; #1;
    check("reg_in1", ex_in1, 32'h1);
    clr_fwd();

    // x0 never forwarded
    set_id(1, 32'h10C, 32'h77, 32'h0, 0, 0, 0, 9, 4'h0, 0, 1, 0, 0);
    step();
    exm_rd = 5'd0; exm_reg_write = 1'b1; exm_result = 32'hBAD;
    #1;
    check("x0_in1", ex_in1, 32'h77);
    clr_fwd();

    // load-use: LW x6 then consumer of x6 in rs2
    set_id(1, 32'h200, 32'h1000, 0, 32'h4, 1, 0, 6, 4'h0, 1, 1, 1, 0);
    step();
    set_id(1, 32'h204, 32'h3, 32'hDEAD, 0, 2, 6, 7, 4'h0, 0, 1, 0, 0);
    #1;
    check("lu_stall", {31'd0, stall_id}, 32'd1);
    step();
    check("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
    check("lu_bub_ctrl", {28'd0, ex_alu_ctrl}, 32'hF);
    check("lu_bub_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    check("lu_cnt", {28'd0, stall_cnt}, 32'd1);
    check("lu_stall_off", {31'd0, stall_id}, 32'd0);
    step();
    wb_rd = 5'd6; wb_reg_write = 1'b1; wb_result = 32'hABC;
    #1;
    check("lu_use_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_use_pc", ex_pc, 32'h204);
    check("lu_use_in2", ex_in2, 32'hABC);
    clr_fwd();

    // taken branch squashes, concurrent load-use not counted
    set_id(1, 32'h240, 32'h1000, 0, 0, 1, 0, 6, 4'h0, 1, 1, 1, 0);
    step();
    set_id(1, 32'h244, 0, 0, 0, 6, 0, 7, 4'h0, 0, 1, 0, 0);
    branch_taken = 1'b1;
    #1;
    check("br_stall_mask", {31'd0, stall_id}, 32'd0);
    step();
    branch_taken = 1'b0;
    check("br_valid", {31'd0, ex_valid}, 32'd0);
    check("br_ctrl", {28'd0, ex_alu_ctrl}, 32'hF);
    check("br_cnt", {28'd0, stall_cnt}, 32'd1);

    // mem_stall holds EX for 3 cycles
    set_id(1, 32'h300, 32'h11, 32'h22, 0, 1, 2, 10, 4'h3, 0, 1, 0, 1);
    step();
    mem_stall = 1'b1;
    set_id(1, 32'h304, 32'h55, 32'h66, 0, 3, 4, 11, 4'h4, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ms_pc", ex_pc, 32'h300);
      check("ms_in1", ex_in1, 32'h11);
      check("ms_ctrl", {28'd0, ex_alu_ctrl}, 32'h3);
      check("ms_mw", {31'd0, ex_mem_write}, 32'd1);
    end
    mem_stall = 1'b0;

    // drive stall_cnt to saturation (CNT_W=4)
    for (int i = 0; i < 14; i++) begin
      set_id(1, 32'h400, 0, 0, 0, 1, 0, 6, 4'h0, 1, 1, 1, 0);
      step();
      set_id(1, 32'h404, 0, 0, 0, 6, 0, 7, 4'h0, 0, 1, 0, 0);
      step();
    end
    check("sat_15", {28'd0, stall_cnt}, 32'd15);
    for (int i = 0; i < 3; i++) begin
      set_id(1, 32'h400, 0, 0, 0, 1, 0, 6, 4'h0, 1, 1, 1, 0);
      step();
      set_id(1, 32'h404, 0, 0, 0, 6, 0, 7, 4'h0, 0, 1, 0, 0);
      step();
    end
    check("sat_hold", {28'd0, stall_cnt}, 32'd15);

    // mid-stream async reset
    set_id(1, 32'h500, 32'h12, 32'h34, 0, 1, 2, 12, 4'h5, 0, 1, 0, 0);
    step();
    check("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mrst_valid", {31'd0, ex_valid}, 32'd0);
    check("mrst_pc", ex_pc, 32'd0);
    check("mrst_ctrl", {28'd0, ex_alu_ctrl}, 32'hF);
    check("mrst_cnt", {28'd0, stall_cnt}, 32'd0);
    check("mrst_in1", ex_in1, 32'd0);
    step();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
